// File: rtl/micro_hash_core_if.sv
// micro_hash_core_if: start/header/nonce request and digest/status response bundle
interface micro_hash_core_if;
  logic        inicio;
  logic [95:0] bloque_bytes;
  logic [31:0] nonce;
  logic        ocupado;
  logic        terminado;
  logic [23:0] hash;
  modport master (output inicio, bloque_bytes, nonce, input ocupado, terminado, hash);
  modport slave (input inicio, bloque_bytes, nonce, output ocupado, terminado, hash);
endinterface

// File: rtl/micro_hash_core.sv
// micro_hash_core: iterative 24-bit hash, one compression round per clock
module micro_hash_core #(
  parameter int ROUNDS = 32
) (
  input  logic             clk,
  input  logic             reset,
  micro_hash_core_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  localparam logic [7:0] H0 = 8'h01;
  localparam logic [7:0] H1 = 8'h89;
  localparam logic [7:0] H2 = 8'hfe;
  localparam logic [4:0] LAST = 5'(ROUNDS - 1);
  state_t           state_q, state_d;
  logic [4:0]       cnt_q;
  logic [7:0]       a_q, b_q, c_q;
  logic [0:15][7:0] w_q;
  logic [23:0]      hash_q;
  logic             term_q;
  logic [7:0]       k, x, w_new;
  // next state and round mixing terms; rounds 0..16 use xor/0x99, later ones or/0xa1
  always_comb begin
    state_d = (state_q == IDLE) ? (bus.inicio ? RUN : IDLE) :
              (state_q == RUN)  ? ((cnt_q == LAST) ? FIN : RUN) : IDLE;
    k = (cnt_q <= 5'd16) ? 8'h99 : 8'ha1;
    x = (cnt_q <= 5'd16) ? (a_q ^ b_q) : (a_q | b_q);
    w_new = w_q[13] | (w_q[7] ^ w_q[2]);
  end
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // datapath: w_q is a sliding window whose slot 0 always holds W[cnt_q]
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      w_q    <= '0;
      hash_q <= '0;
      term_q <= 1'b0;
    end else begin
      term_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.inicio) begin
          w_q   <= {bus.bloque_bytes, bus.nonce};
          a_q   <= H0;
          b_q   <= H1;
          c_q   <= H2;
          cnt_q <= '0;
        end
        RUN: begin
          a_q   <= b_q ^ c_q;
          b_q   <= {c_q[3:0], 4'h0};
          c_q   <= x + k + w_q[0];
          w_q   <= {w_q[1:15], w_new};
          cnt_q <= cnt_q + 5'd1;
        end
        FIN: begin
          hash_q <= {H0 + a_q, H1 + b_q, H2 + c_q};
          term_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign bus.ocupado   = (state_q != IDLE) | term_q;
  assign bus.terminado = term_q;
  assign bus.hash      = hash_q;
endmodule

// File: tb/tb_micro_hash_core.sv
// tb_micro_hash_core: vector table, lockout, back-to-back and reset checks against a byte-level model
module tb_micro_hash_core;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  micro_hash_core_if bus();
  micro_hash_core #(.ROUNDS(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [95:0] blk;
    logic [31:0] nonce;
    logic [23:0] exp;
  } vec_t;
  function automatic logic [23:0] model(input logic [95:0] blk, input logic [31:0] n);
    logic [7:0] w [32];
    logic [7:0] a, b, c, na, nb, nc, x, k;
    logic [127:0] msg;
    msg = {blk, n};
    for (int i = 0; i < 16; i++) w[i] = msg[127 - 8 * i -: 8];
    for (int i = 16; i < 32; i++) w[i] = w[i - 3] | (w[i - 9] ^ w[i - 14]);
    a = 8'h01;
    b = 8'h89;
    c = 8'hfe;
    for (int i = 0; i < 32; i++) begin
      if (i <= 16) begin
        k = 8'h99;
        x = a ^ b;
      end else begin
        k = 8'ha1;
        x = a | b;
      end
      na = b ^ c;
      nb = 8'((c * 16) % 256);
      nc = 8'((x + k + w[i]) % 256);
      a = na;
      b = nb;
      c = nc;
    end
    return {8'(8'h01 + a), 8'(8'h89 + b), 8'(8'hfe + c)};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run_hash(input logic [95:0] blk, input logic [31:0] n, input logic [23:0] exp);
    int lat;
    bus.bloque_bytes = blk;
    bus.nonce = n;
    bus.inicio = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.inicio = 1'b0;
    chk("busy_after_accept", 64'(bus.ocupado), 64'd1);
    lat = 0;
    for (int j = 1; j <= 100; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.terminado) begin
        lat = j;
        break;
      end
    end
    chk("latency", 64'(lat), 64'd33);
    chk("hash", 64'(bus.hash), 64'(exp));
    chk("busy_in_done", 64'(bus.ocupado), 64'd1);
    @(negedge clk);
    chk("done_one_cycle", 64'(bus.terminado), 64'd0);
    chk("idle_after", 64'(bus.ocupado), 64'd0);
  endtask
  initial begin
    vec_t vecs [9];
    logic [95:0] blk;
    logic [31:0] n;
    int tcount, lat, last, got;
    bus.inicio = 1'b0;
    bus.bloque_bytes = '0;
    bus.nonce = '0;
    vecs[0] = '{96'h73a9debe6af9c95e9f052d59, 32'h0, 24'h0};
    vecs[1] = '{96'h73a9debe6af9c95e9f052d59, 32'h1, 24'h0};
    vecs[2] = '{96'h73a9debe6af9c95e9f052d59, 32'hffffffff, 24'h0};
    vecs[3] = '{96'h0, 32'h0, 24'h0};
    vecs[4] = '{{12{8'hff}}, 32'hffffffff, 24'h0};
    for (int i = 5; i < 9; i++) vecs[i] = '{{$urandom, $urandom, $urandom}, $urandom, 24'h0};
    for (int i = 0; i < 9; i++) vecs[i].exp = model(vecs[i].blk, vecs[i].nonce);
    repeat (15) @(negedge clk);
    chk("rst_hash", 64'(bus.hash), 64'd0);
    chk("rst_done", 64'(bus.terminado), 64'd0);
    chk("rst_busy", 64'(bus.ocupado), 64'd0);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("idle_hash", 64'(bus.hash), 64'd0);
    chk("idle_done", 64'(bus.terminado), 64'd0);
    chk("idle_busy", 64'(bus.ocupado), 64'd0);
    for (int i = 0; i < 9; i++) run_hash(vecs[i].blk, vecs[i].nonce, vecs[i].exp);
    blk = {$urandom, $urandom, $urandom};
    n = $urandom;
    bus.bloque_bytes = blk;
    bus.nonce = n;
    bus.inicio = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.inicio = 1'b0;
    bus.nonce = n ^ 32'h5a5a0001;
    tcount = 0;
    lat = 0;
    for (int j = 1; j <= 80; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.terminado) begin
        tcount++;
        if (tcount == 1) lat = j;
      end
      bus.inicio = (j == 5 || j == 31 || j == 32);
    end
    chk("lockout_count", 64'(tcount), 64'd1);
    chk("lockout_latency", 64'(lat), 64'd33);
    chk("lockout_hash", 64'(bus.hash), 64'(model(blk, n)));
    n = $urandom;
    bus.nonce = n;
    bus.inicio = 1'b1;
    last = 0;
    for (int h = 0; h < 8; h++) begin
      logic [31:0] cur;
      @(posedge clk);
      @(negedge clk);
      cur = bus.nonce;
      bus.nonce = bus.nonce + 32'd1;
      got = 0;
      for (int j = 0; j < 100; j++) begin
        @(posedge clk);
        @(negedge clk);
        if (bus.terminado) begin
          got = 1;
          break;
        end
      end
      if (h == 7) bus.inicio = 1'b0;
      chk("b2b_seen", 64'(got), 64'd1);
      chk("b2b_hash", 64'(bus.hash), 64'(model(blk, cur)));
      if (h > 0) chk("b2b_spacing", 64'(cyc - last), 64'd34);
      last = cyc;
    end
    repeat (3) @(negedge clk);
    chk("b2b_stop", 64'(bus.ocupado), 64'd0);
    bus.nonce = 32'h1234;
    bus.inicio = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.inicio = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.ocupado), 64'd0);
    chk("mid_rst_done", 64'(bus.terminado), 64'd0);
    chk("mid_rst_hash", 64'(bus.hash), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tcount = 0;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (bus.terminado) tcount++;
    end
    chk("mid_rst_no_done", 64'(tcount), 64'd0);
    run_hash(blk, 32'h1234, model(blk, 32'h1234));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
